dual_issue_fetch_buffer: RTL

//  Instruction buffer between dual-fetch and dual-decode (the IF/ID boundary) of the superscalar core.

---
 rtl/dual_issue_fetch_buffer.sv | 98 +++++++++
 1 files changed

// File: rtl/dual_issue_fetch_buffer.sv
// IF/ID instruction buffer for the dual-issue core: a circular FIFO of
// {instr, pc, pred} that presents its two oldest entries to decode.
module dual_issue_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fValid1,
    input  logic                       fValid2,
    input  logic [IW-1:0]              fInstr1,
    input  logic [IW-1:0]              fInstr2,
    input  logic [AW-1:0]              fPC1,
    input  logic [AW-1:0]              fPC2,
    input  logic                       fPred1,
    input  logic                       fPred2,
    output logic                       fReady,
    input  logic                       stallD1,
    input  logic                       stallD2,
    input  logic                       flush,
    output logic                       dValid1,
    output logic                       dValid2,
    output logic [IW-1:0]              dInstr1,
    output logic [IW-1:0]              dInstr2,
    output logic [AW-1:0]              dPC1,
    output logic [AW-1:0]              dPC2,
    output logic                       dPred1,
    output logic                       dPred2,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IW-1:0] memInstr [DEPTH];
    logic [AW-1:0] memPC    [DEPTH];
    logic          memPred  [DEPTH];

    logic [PW-1:0] head, tail;
    logic [PW-1:0] headNext, tailNext;
    logic          pop1, pop2, push1, push2;
    logic [1:0]    npop, npush;

    assign headNext = head + PW'(1);
    assign tailNext = tail + PW'(1);

    // Handshake: fetch offers a pair with fValid1 (fValid2 only alongside it);
    // the pair is taken on an edge where fValid1 & fReady. fReady depends only
    // on the registered count, so stalls never reach fetch combinationally.
    assign fReady  = (count <= CW'(DEPTH - 2));
    assign dValid1 = (count != '0);
    assign dValid2 = (count >= CW'(2));

    assign pop1  = dValid1 & ~stallD1;
    assign pop2  = pop1 & dValid2 & ~stallD2;
    assign push1 = fReady & fValid1;
    assign push2 = push1 & fValid2;
    assign npop  = {1'b0, pop1} + {1'b0, pop2};
    assign npush = {1'b0, push1} + {1'b0, push2};

    // Invalid slots present a NOP with zero PC/prediction.
    assign dInstr1 = dValid1 ? memInstr[head]     : '0;
    assign dPC1    = dValid1 ? memPC[head]        : '0;
    assign dPred1  = dValid1 ? memPred[head]      : 1'b0;
    assign dInstr2 = dValid2 ? memInstr[headNext] : '0;
    assign dPC2    = dValid2 ? memPC[headNext]    : '0;
    assign dPred2  = dValid2 ? memPred[headNext]  : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(npop);
            tail  <= tail + PW'(npush);
            count <= count + CW'(npush) - CW'(npop);
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push1 && !flush) begin
            memInstr[tail] <= fInstr1;
            memPC[tail]    <= fPC1;
            memPred[tail]  <= fPred1;
        end
        if (push2 && !flush) begin
            memInstr[tailNext] <= fInstr2;
            memPC[tailNext]    <= fPC2;
            memPred[tailNext]  <= fPred2;
        end
    end
endmodule
